// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the pipelined register file.
// ADDR_W and the PC index derive from NUM_REGS and cannot be overridden.
package regfile_pkg;

   localparam int unsigned DefDataW      = 32;
   localparam int unsigned DefNumRegs    = 16;
   localparam int unsigned DefNumRdPorts = 3;
   localparam int unsigned DefMaxPending = 3;
   localparam int unsigned DefPcIdx      = DefNumRegs - 1;

   function automatic int unsigned addr_w(input int unsigned num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   // The highest index is always the PC register.
   function automatic int unsigned pc_index(input int unsigned num_regs);
      return num_regs - 1;
   endfunction

endpackage

// File: rtl/pipelined_register_file_module_if.sv
// Read, writeback, PC, allocation and flush bundle of the register file.
// The master side drives addresses and writebacks; the slave side is the register file.
interface pipelined_register_file_module_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W       = DefDataW,
   parameter int unsigned NUM_REGS     = DefNumRegs,
   parameter int unsigned NUM_RD_PORTS = DefNumRdPorts
);
   localparam int unsigned ADDR_W = addr_w(NUM_REGS);

   logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addrs;
   logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_data;
   logic [NUM_RD_PORTS-1:0]             rd_busy;
   logic                                wrt_ena;
   logic [ADDR_W-1:0]                   wrt_addrs;
   logic [DATA_W-1:0]                   wrt_data;
   logic [DATA_W-1:0]                   pc_data;
   logic [DATA_W-1:0]                   pc_out;
   logic                                alloc_ena;
   logic [ADDR_W-1:0]                   alloc_addrs;
   logic                                alloc_rdy;
   logic                                flush;
   logic                                wb_err;

   modport master (
      output rd_addrs, wrt_ena, wrt_addrs, wrt_data, pc_data, alloc_ena, alloc_addrs, flush,
      input  rd_data, rd_busy, pc_out, alloc_rdy, wb_err
   );

   modport slave (
      input  rd_addrs, wrt_ena, wrt_addrs, wrt_data, pc_data, alloc_ena, alloc_addrs, flush,
      output rd_data, rd_busy, pc_out, alloc_rdy, wb_err
   );

endinterface

// File: rtl/pending_counter_module.sv
// Outstanding-write counter for one register: saturating increment on allocation,
// non-underflowing decrement on writeback, synchronous flush to zero.
module pending_counter_module
   import regfile_pkg::*;
#(
   parameter int unsigned MAX_PENDING = DefMaxPending,
   localparam int unsigned CNT_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc,
   input  logic             wb,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc;

   assign full  = (cnt_q == CNT_W'(MAX_PENDING));
   assign inc   = alloc && !full;
   assign count = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else if (inc && !wb) begin
         cnt_d = cnt_q + 1'b1;
      end else if (wb && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
      // inc && wb on the same edge cancel out
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pipelined_register_file_module.sv
// Multi-ported register file with a PC register and per-register pending-write scoreboard.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writebacks to the read ports.
module pipelined_register_file_module
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W       = DefDataW,
   parameter int unsigned NUM_REGS     = DefNumRegs,
   parameter int unsigned NUM_RD_PORTS = DefNumRdPorts,
   parameter int unsigned MAX_PENDING  = DefMaxPending
) (
   input logic                             clk,
   input logic                             rst_n,
   pipelined_register_file_module_if.slave bus
);

   localparam int unsigned ADDR_W = addr_w(NUM_REGS);
   localparam int unsigned PC_IDX = pc_index(NUM_REGS);
   localparam int unsigned CNT_W  = $clog2(MAX_PENDING + 1);
   localparam int unsigned NGPR   = NUM_REGS - 1;

   logic [DATA_W-1:0] regs_q [NGPR];
   logic [DATA_W-1:0] pc_q;
   logic              wb_err_q;
   logic [CNT_W-1:0]  cnt [NGPR];
   logic [NGPR-1:0]   alloc_hit, wb_hit, cnt_full, cnt_empty;
   logic              pc_wr;

   for (genvar g = 0; g < NGPR; g++) begin : g_cnt
      assign alloc_hit[g] = bus.alloc_ena && (bus.alloc_addrs == ADDR_W'(g));
      assign wb_hit[g]    = bus.wrt_ena && (bus.wrt_addrs == ADDR_W'(g));
      assign cnt_empty[g] = (cnt[g] == '0);

      pending_counter_module #(
         .MAX_PENDING (MAX_PENDING)
      ) u_pending (
         .clk   (clk),
         .rst_n (rst_n),
         .alloc (alloc_hit[g]),
         .wb    (wb_hit[g]),
         .flush (bus.flush),
         .count (cnt[g]),
         .full  (cnt_full[g])
      );
   end

   assign pc_wr = bus.wrt_ena && (bus.wrt_addrs == ADDR_W'(PC_IDX));

   // PC never matches a counter, so it always reads as ready.
   assign bus.alloc_rdy = ~|(alloc_hit & cnt_full) || !bus.alloc_ena ? ~|(
      {NGPR{1'b1}} & cnt_full & alloc_sel(bus.alloc_addrs)) : ~|(alloc_hit & cnt_full);

   function automatic logic [NGPR-1:0] alloc_sel(input logic [ADDR_W-1:0] addr);
      logic [NGPR-1:0] sel;
      sel = '0;
      for (int i = 0; i < NGPR; i++) begin
         sel[i] = (addr == ADDR_W'(i));
      end
      return sel;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NGPR; i++) begin
            regs_q[i] <= '0;
         end
         pc_q     <= '0;
         wb_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NGPR; i++) begin
            if (wb_hit[i]) begin
               regs_q[i] <= bus.wrt_data;
            end
         end
         pc_q <= pc_wr ? bus.wrt_data : bus.pc_data;
         if (|(wb_hit & cnt_empty)) begin
            wb_err_q <= 1'b1;
         end
      end
   end

   assign bus.pc_out = pc_q;
   assign bus.wb_err = wb_err_q;

   always_comb begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         bus.rd_data[p] = '0;
         bus.rd_busy[p] = 1'b0;
         if (bus.rd_addrs[p] == ADDR_W'(PC_IDX)) begin
            bus.rd_data[p] = pc_q;
         end
         for (int i = 0; i < NGPR; i++) begin
            if (bus.rd_addrs[p] == ADDR_W'(i)) begin
               bus.rd_data[p] = regs_q[i];
               bus.rd_busy[p] = !cnt_empty[i];
`ifdef REGFILE_WRITE_BYPASS_EN
               // The last outstanding write lands this cycle, so the value is usable now.
               if (wb_hit[i] && (cnt[i] == CNT_W'(1))) begin
                  bus.rd_busy[p] = 1'b0;
               end
`endif
            end
         end
`ifdef REGFILE_WRITE_BYPASS_EN
         if (rst_n && bus.wrt_ena && (bus.wrt_addrs == bus.rd_addrs[p])) begin
            bus.rd_data[p] = bus.wrt_data;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_register_file_module.sv
// Randomized and directed scoreboard bench for pipelined_register_file_module.
// Build with and without REGFILE_WRITE_BYPASS_EN; the reference model follows the same macro.
module tb_pipelined_register_file_module;
   import regfile_pkg::*;

   localparam int DW = 32;
   localparam int NR = 16;
   localparam int NP = 3;
   localparam int MP = 3;
   localparam int PC = NR - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipelined_register_file_module_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) bus ();

   pipelined_register_file_module #(
      .DATA_W       (DW),
      .NUM_REGS     (NR),
      .NUM_RD_PORTS (NP),
      .MAX_PENDING  (MP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [NP-1:0][DW-1:0] rd_data;
      logic [NP-1:0]         busy;
      logic [DW-1:0]         pc;
      logic                  rdy;
      logic                  err;
      int                    cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Stimulus for the next cycle (s_*) and the inputs currently applied (a_*).
   logic [3:0]  s_rd [NP];
   logic        s_wen, s_aen, s_fl, s_rst;
   logic [3:0]  s_wa, s_aa;
   logic [31:0] s_wd, s_pc;
   logic [3:0]  a_rd [NP];
   logic        a_wen, a_aen, a_fl, a_rst;
   logic [3:0]  a_wa, a_aa;
   logic [31:0] a_wd, a_pc;

   // Reference model state.
   logic [31:0] m_reg [NR];
   logic [31:0] m_pc;
   int          m_cnt [NR];
   logic        m_err;

   task automatic m_reset();
      for (int i = 0; i < NR; i++) begin
         m_reg[i] = '0;
         m_cnt[i] = 0;
      end
      m_pc  = '0;
      m_err = 1'b0;
   endtask

   task automatic m_update();
      int w, a;
      bit acc;
      if (!a_rst) return;
      w   = int'(a_wa);
      a   = int'(a_aa);
      acc = a_aen && (a != PC) && (m_cnt[a] < MP);
      m_pc = (a_wen && w == PC) ? a_wd : a_pc;
      if (a_wen && w != PC) begin
         m_reg[w] = a_wd;
         if (m_cnt[w] == 0) m_err = 1'b1;
      end
      if (a_fl) begin
         for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      end else if (!(acc && a_wen && a == w)) begin
         if (acc) m_cnt[a]++;
         if (a_wen && w != PC && m_cnt[w] > 0) m_cnt[w]--;
      end
   endtask

   task automatic push_expected();
      exp_t e;
      e.cyc = cyc;
      if (!a_rst) begin
         e.rd_data = '0;
         e.busy    = '0;
         e.pc      = '0;
         e.rdy     = 1'b1;
         e.err     = 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            int r;
            r = int'(a_rd[p]);
            e.rd_data[p] = (r == PC) ? m_pc : m_reg[r];
            e.busy[p]    = (r != PC) && (m_cnt[r] != 0);
`ifdef REGFILE_WRITE_BYPASS_EN
            if (a_wen && a_wa == a_rd[p]) begin
               e.rd_data[p] = a_wd;
               if (r != PC && m_cnt[r] == 1) e.busy[p] = 1'b0;
            end
`endif
         end
         e.pc  = m_pc;
         e.rdy = (int'(a_aa) == PC) || (m_cnt[a_aa] < MP);
         e.err = m_err;
      end
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      m_update();
      #1;
      a_rd  = s_rd;
      a_wen = s_wen; a_wa = s_wa; a_wd = s_wd; a_pc = s_pc;
      a_aen = s_aen; a_aa = s_aa; a_fl = s_fl; a_rst = s_rst;
      for (int p = 0; p < NP; p++) bus.rd_addrs[p] = a_rd[p];
      bus.wrt_ena     = a_wen;
      bus.wrt_addrs   = a_wa;
      bus.wrt_data    = a_wd;
      bus.pc_data     = a_pc;
      bus.alloc_ena   = a_aen;
      bus.alloc_addrs = a_aa;
      bus.flush       = a_fl;
      rst_n           = a_rst;
      if (!a_rst) m_reset();
      cyc++;
      push_expected();
   endtask

   task automatic idle();
      s_wen = 1'b0; s_aen = 1'b0; s_fl = 1'b0; s_rst = 1'b1;
      s_wa  = 4'($urandom); s_aa = 4'($urandom);
      s_wd  = $urandom; s_pc = $urandom;
   endtask

   task automatic rand_inputs();
      for (int p = 0; p < NP; p++) s_rd[p] = 4'($urandom);
      s_wen = ($urandom_range(0, 1) == 1);
      s_aen = ($urandom_range(0, 2) != 0);
      s_wa  = 4'($urandom_range(0, 15));
      s_aa  = 4'($urandom_range(0, 15));
      s_wd  = $urandom;
      s_pc  = $urandom;
      s_fl  = ($urandom_range(0, 49) == 0);
      s_rst = ($urandom_range(0, 199) != 0);
   endtask

   task automatic chk(input string name, input int c, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h, want %0h", name, c, act, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         for (int p = 0; p < NP; p++) begin
            chk($sformatf("rd_data%0d", p), e.cyc, bus.rd_data[p], e.rd_data[p]);
            chk($sformatf("rd_busy%0d", p), e.cyc, 32'(bus.rd_busy[p]), 32'(e.busy[p]));
         end
         chk("pc_out", e.cyc, bus.pc_out, e.pc);
         chk("alloc_rdy", e.cyc, 32'(bus.alloc_rdy), 32'(e.rdy));
         chk("wb_err", e.cyc, 32'(bus.wb_err), 32'(e.err));
      end
   end

   initial begin
      rst_n = 1'b0;
      a_rst = 1'b0;
      for (int p = 0; p < NP; p++) begin
         s_rd[p] = '0;
         a_rd[p] = '0;
         bus.rd_addrs[p] = '0;
      end
      bus.wrt_ena = 1'b0; bus.wrt_addrs = '0; bus.wrt_data = '0; bus.pc_data = '0;
      bus.alloc_ena = 1'b0; bus.alloc_addrs = '0; bus.flush = 1'b0;
      m_reset();

      // Reset held with random inputs.
      repeat (3) begin
         rand_inputs();
         s_rst = 1'b0;
         step();
      end

      // Saturate R3, then drain it with writebacks.
      s_rd[0] = 4'd3; s_rd[1] = 4'd5; s_rd[2] = 4'd7;
      idle(); step();
      repeat (4) begin
         idle(); s_aen = 1'b1; s_aa = 4'd3; step();
      end
      idle(); s_wen = 1'b1; s_wa = 4'd3; s_wd = 32'h55; step();
      idle(); s_aa = 4'd3; step();
      repeat (2) begin
         idle(); s_wen = 1'b1; s_wa = 4'd3; step();
      end
      idle(); step();

      // Simultaneous allocation and writeback on R5 with count 1.
      idle(); s_aen = 1'b1; s_aa = 4'd5; step();
      idle(); s_aen = 1'b1; s_aa = 4'd5; s_wen = 1'b1; s_wa = 4'd5; s_wd = 32'hA; step();
      idle(); step();

      // Unallocated writeback, then flush with three registers pending.
      idle(); s_wen = 1'b1; s_wa = 4'd7; s_wd = 32'h1234; step();
      idle(); step();
      s_rd[0] = 4'd1; s_rd[1] = 4'd2; s_rd[2] = 4'd4;
      idle(); s_aen = 1'b1; s_aa = 4'd1; step();
      idle(); s_aen = 1'b1; s_aa = 4'd2; step();
      idle(); s_aen = 1'b1; s_aa = 4'd4; step();
      idle(); step();
      idle(); s_fl = 1'b1; s_aen = 1'b1; s_aa = 4'd1; step();
      idle(); step();

      // PC load from pc_data and from a writeback.
      s_rd[2] = 4'd15;
      idle(); s_pc = 32'h100; step();
      idle(); s_wen = 1'b1; s_wa = 4'd15; s_wd = 32'h200; s_pc = 32'h104; step();
      idle(); step();

      // Bypass: R2 holds 0x1, written 0x9 while port 0 reads it; also with count 1.
      idle(); s_wen = 1'b1; s_wa = 4'd2; s_wd = 32'h1; step();
      idle(); s_aen = 1'b1; s_aa = 4'd2; step();
      idle(); s_rd[0] = 4'd2; s_wen = 1'b1; s_wa = 4'd2; s_wd = 32'h9; step();
      idle(); step();

      // Random traffic with occasional flush and mid-operation reset.
      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         step();
      end
      idle(); step();

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_register_file_module.md
PIPELINED_REGISTER_FILE_MODULE -- requirements
Module: pipelined_register_file_module

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; index NUM_REGS-1 is the PC register.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 3, independent read port count.
REQ-004 SHALL have parameter MAX_PENDING, default 3, maximum outstanding writes tracked per register.
REQ-005 SHALL derive ADDR_W = clog2(NUM_REGS), and SHALL NOT expose it as an override.
REQ-006 SHALL have port CLK  input  1  single clock, all state on its rising edge.
REQ-007 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port RD_ADDRS  input  NUM_RD_PORTS x ADDR_W  read addresses.
REQ-009 SHALL have port RD_DATA  output  NUM_RD_PORTS x DATA_W  read data.
REQ-010 SHALL have port RD_BUSY  output  NUM_RD_PORTS  addressed register has pending writes.
REQ-011 SHALL have ports WRT_ENA (input, 1), WRT_ADDRS (input, ADDR_W) and WRT_DATA (input, DATA_W), forming the writeback port.
REQ-012 SHALL have port PC_DATA  input  DATA_W  next-PC value loaded every cycle.
REQ-013 SHALL have port PC_OUT  output  DATA_W  current PC register value.
REQ-014 SHALL have ports ALLOC_ENA (input, 1), ALLOC_ADDRS (input, ADDR_W) and ALLOC_RDY (output, 1), forming the destination-allocation handshake.
REQ-015 SHALL have port FLUSH  input  1  clears all pending counts.
REQ-016 SHALL have port WB_ERR  output  1  sticky flag: writeback to a register with no pending allocation.

Function
REQ-017 SHALL drive RD_DATA combinationally, zero-cycle latency, from the stored value at RD_ADDRS.
REQ-018 SHALL, on a rising edge with WRT_ENA=1, store WRT_DATA into a non-PC register at WRT_ADDRS.
REQ-019 SHALL load the PC register every edge: WRT_DATA if WRT_ENA=1 and WRT_ADDRS=NUM_REGS-1, otherwise PC_DATA.
REQ-020 SHALL keep one pending counter per non-PC register, range 0..MAX_PENDING.
REQ-021 SHALL drive ALLOC_RDY=0 when the counter of ALLOC_ADDRS equals MAX_PENDING, and 1 otherwise (combinational).
REQ-022 SHALL increment the counter of ALLOC_ADDRS on an edge only when ALLOC_ENA=1 and ALLOC_RDY=1 (accepted allocation).
REQ-023 SHALL decrement the counter of WRT_ADDRS on an edge with WRT_ENA=1 when that counter is nonzero.
REQ-024 SHALL leave a counter unchanged when an accepted allocation and a writeback target the same register on the same edge.
REQ-025 SHALL set WB_ERR on an edge with WRT_ENA=1 to a non-PC register whose counter is 0, SHALL perform the data write, SHALL NOT underflow the counter, and SHALL hold WB_ERR until reset.
REQ-026 SHALL clear every counter to 0 on an edge with FLUSH=1, overriding allocation and decrement; data and PC writes SHALL still occur.
REQ-027 SHALL exclude the PC register from scoreboarding: allocations to it are ignored, ALLOC_RDY=1, RD_BUSY=0, and WB_ERR is never set by a write to it.
REQ-028 SHALL drive RD_BUSY[p]=1 when the counter of RD_ADDRS[p] is nonzero, except as modified by REQ-032.

Reset
REQ-029 SHALL, while RST=0, asynchronously clear every register including the PC register, every counter, and WB_ERR.
REQ-030 SHALL hold the following values in reset: RD_DATA=0 for all ports, PC_OUT=0, RD_BUSY=0, ALLOC_RDY=1, WB_ERR=0.
REQ-031 SHALL take reset asserted mid-operation immediately; allocations and writebacks in flight are discarded, and operation resumes on the first edge after RST returns to 1.

Configuration
REQ-032 SHALL, with macro REGFILE_WRITE_BYPASS_EN defined, forward WRT_DATA to RD_DATA[p] combinationally when WRT_ENA=1 and WRT_ADDRS=RD_ADDRS[p], and drive RD_BUSY[p]=0 when that counter equals 1; without the macro, reads return the stored value and RD_BUSY follows REQ-028 only.

Structure
REQ-033 SHALL place default parameter values, the ADDR_W derivation function and the PC-index constant in shared package REGFILE_PKG.
REQ-034 SHALL implement each pending counter, including increment, decrement, saturation and flush, as sub-module PENDING_COUNTER_MODULE, instantiated NUM_REGS-1 times.

Verification
REQ-035 SHALL cover reset: RST=0 with random inputs -> all RD_DATA=0, PC_OUT=0, ALLOC_RDY=1, WB_ERR=0.
REQ-036 SHALL cover scoreboard: allocate R3 three times -> ALLOC_RDY=0 for R3, fourth allocation ignored; writeback R3=0x55 -> count 2, RD_BUSY stays 1 until two more writebacks.
REQ-037 SHALL cover simultaneous events: allocate R5 and write back R5=0xA on the same edge with count 1 -> count stays 1, R5 reads 0xA next cycle.
REQ-038 SHALL cover the error path: write back R7=0x1234 with count 0 -> R7=0x1234, WB_ERR=1 and stays 1; FLUSH with three registers pending -> all RD_BUSY=0 next cycle.
REQ-039 SHALL cover PC load: PC_DATA=0x100 with no PC write -> PC_OUT=0x100; WRT_ENA to index 15 with 0x200 and PC_DATA=0x104 -> PC_OUT=0x200.
REQ-040 SHALL cover bypass, built with and without REGFILE_WRITE_BYPASS_EN: R2 holding 0x1 and written 0x9 while RD_ADDRS[0]=2 -> RD_DATA[0]=0x9 with macro, 0x1 without.
